// File: rtl/kernel_seq_pkg.sv
// kernel_seq_pkg: shared state encoding and accelerator register map for the kernel load sequencer
package kernel_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, COMMIT, WAIT_DONE, DRAIN, RELEASE, WAIT_REL} state_t;
    localparam logic [2:0] LOAD_REG = 3'h3;
    localparam logic [2:0] READ_REG = 3'h4;
    localparam int DATA_W = 16;
endpackage

// File: rtl/kernel_seq_timer.sv
// kernel_seq_timer: saturating wait counter; expired holds once TIMEOUT cycles have been counted
module kernel_seq_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] MAX = TW'(TIMEOUT);
    logic [TW-1:0] cnt_q, cnt_d;
    // next count: clear wins, otherwise count up and stick at MAX
    always_comb cnt_d = clr ? '0 : (en && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    // timer register
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
    assign expired = cnt_q == MAX;
endmodule

// File: rtl/kernel_load_sequencer.sv
// kernel_load_sequencer: streams WORDS source words into the accelerator, commits, then drains results to SRAM
module kernel_load_sequencer #(
    parameter int WORDS = 25,
    parameter int ADDR_BITS = 5,
    parameter int DATA_W = kernel_seq_pkg::DATA_W,
    parameter logic [2:0] LOAD_REG = kernel_seq_pkg::LOAD_REG,
    parameter logic [2:0] READ_REG = kernel_seq_pkg::READ_REG,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 complete,
    output logic                 error,
    output logic                 src_rd,
    output logic [ADDR_BITS-1:0] src_addr,
    input  logic [DATA_W-1:0]    src_rdata,
    output logic                 dst_we,
    output logic [ADDR_BITS-1:0] dst_addr,
    output logic [DATA_W-1:0]    dst_wdata,
    output logic                 acc_chipselect,
    output logic [2:0]           acc_address,
    output logic                 acc_write,
    output logic                 acc_read,
    output logic [DATA_W-1:0]    acc_writedata,
    input  logic [DATA_W-1:0]    acc_readdata,
    input  logic                 acc_done
);
    import kernel_seq_pkg::*;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(WORDS - 1);
    state_t state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d, src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
    logic [2:0] acc_address_q, acc_address_d;
    logic src_rd_q, src_rd_d, dst_we_q, dst_we_d, acc_write_q, acc_write_d, acc_read_q, acc_read_d;
    logic complete_q, complete_d, error_q, error_d;
    logic waiting, expired;
    assign waiting = state_q == WAIT_DONE || state_q == WAIT_REL;
    kernel_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .reset(reset), .clr(!waiting), .en(waiting), .expired(expired)
    );
    // next state and next-cycle strobes; a read strobed this cycle yields its write next cycle
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        src_rd_d = 1'b0;
        src_addr_d = '0;
        dst_we_d = 1'b0;
        dst_addr_d = '0;
        acc_write_d = 1'b0;
        acc_read_d = 1'b0;
        acc_address_d = 3'h0;
        complete_d = 1'b0;
        error_d = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = LOAD;
                    cnt_d = '0;
                    src_rd_d = 1'b1;
                end
                LOAD: begin
                    acc_write_d = 1'b1;
                    acc_address_d = LOAD_REG;
                    if (!src_rd_q) state_d = COMMIT;
                    else if (cnt_q != LAST) begin
                        cnt_d = cnt_q + 1'b1;
                        src_rd_d = 1'b1;
                        src_addr_d = cnt_q + 1'b1;
                    end
                end
                COMMIT: state_d = WAIT_DONE;
                WAIT_DONE: if (acc_done) begin
                    state_d = DRAIN;
                    cnt_d = '0;
                    acc_read_d = 1'b1;
                    acc_address_d = READ_REG;
                end else if (expired) begin
                    state_d = IDLE;
                    complete_d = 1'b1;
                    error_d = 1'b1;
                end
                DRAIN: if (!acc_read_q) begin
                    state_d = RELEASE;
                    acc_read_d = 1'b1;
                    acc_address_d = READ_REG;
                end else begin
                    dst_we_d = 1'b1;
                    dst_addr_d = cnt_q;
                    if (cnt_q != LAST) begin
                        cnt_d = cnt_q + 1'b1;
                        acc_read_d = 1'b1;
                        acc_address_d = READ_REG;
                    end
                end
                RELEASE: state_d = WAIT_REL;
                WAIT_REL: if (!acc_done || expired) begin
                    state_d = IDLE;
                    complete_d = 1'b1;
                    error_d = acc_done;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            src_rd_q <= 1'b0;
            src_addr_q <= '0;
            dst_we_q <= 1'b0;
            dst_addr_q <= '0;
            acc_write_q <= 1'b0;
            acc_read_q <= 1'b0;
            acc_address_q <= 3'h0;
            complete_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            src_rd_q <= src_rd_d;
            src_addr_q <= src_addr_d;
            dst_we_q <= dst_we_d;
            dst_addr_q <= dst_addr_d;
            acc_write_q <= acc_write_d;
            acc_read_q <= acc_read_d;
            acc_address_q <= acc_address_d;
            complete_q <= complete_d;
            error_q <= error_d;
        end
    end
    assign busy = state_q != IDLE;
    assign complete = complete_q;
    assign error = error_q;
    assign src_rd = src_rd_q;
    assign src_addr = src_addr_q;
    assign dst_we = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_wdata = dst_we_q ? acc_readdata : '0;
    assign acc_write = acc_write_q;
    assign acc_read = acc_read_q;
    assign acc_address = acc_address_q;
    assign acc_chipselect = acc_write_q | acc_read_q;
    assign acc_writedata = (acc_write_q && state_q == LOAD) ? src_rdata : '0;
endmodule

// File: tb/tb_kernel_load_sequencer.sv
// tb_kernel_load_sequencer: randomized directed scenarios against SRAM and accelerator models
module tb_kernel_load_sequencer;
    import kernel_seq_pkg::*;
    logic clk = 0, reset = 1, start = 0, abort = 0;
    logic busy, complete, error, src_rd, dst_we, acc_chipselect, acc_write, acc_read;
    logic [4:0] src_addr, dst_addr;
    logic [2:0] acc_address;
    logic [15:0] dst_wdata, acc_writedata;
    logic [15:0] src_rdata = 0, acc_readdata = 0;
    logic acc_done = 0;
    always #5 clk = ~clk;

    kernel_load_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .complete(complete),
        .error(error), .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata), .dst_we(dst_we),
        .dst_addr(dst_addr), .dst_wdata(dst_wdata), .acc_chipselect(acc_chipselect),
        .acc_address(acc_address), .acc_write(acc_write), .acc_read(acc_read),
        .acc_writedata(acc_writedata), .acc_readdata(acc_readdata), .acc_done(acc_done)
    );

    // source SRAM and accelerator model: 25 loads then a commit, results are load+5
    logic [15:0] src_mem [32];
    logic [15:0] ld [25];
    int ld_n = 0, rd_n = 0, dcnt = -1, done_dly = 0, rel_dly = 0;
    logic pend = 0, model_clr = 0, never_done = 0, pre_done = 0;
    always @(posedge clk) begin
        src_rdata <= src_mem[src_addr];
        if (model_clr) begin
            ld_n <= 0;
            rd_n <= 0;
            dcnt <= -1;
            acc_done <= pre_done;
            pend <= pre_done;
        end else begin
            if (dcnt > 0) dcnt <= dcnt - 1;
            if (dcnt == 0) begin
                acc_done <= pend;
                dcnt <= -1;
            end
            if (acc_write && acc_address == LOAD_REG) begin
                if (ld_n < 25) ld[ld_n] <= acc_writedata;
                else if (!never_done) begin
                    pend <= 1;
                    dcnt <= done_dly;
                end
                ld_n <= ld_n + 1;
            end
            if (acc_read && acc_address == READ_REG) begin
                acc_readdata <= rd_n < 25 ? ld[rd_n] + 16'd5 : 16'hbeef;
                if (rd_n == 25) begin
                    pend <= 0;
                    dcnt <= rel_dly;
                end
                rd_n <= rd_n + 1;
            end
        end
    end

    // bus monitor: logs every strobe with its cycle number
    int cyc = 0, comp_cnt = 0, comp_cyc = 0, bad_cnt = 0;
    logic comp_err = 0;
    int wr_cyc[$], rd_cyc[$], sa_log[$], da_log[$];
    logic [15:0] wr_dat[$], dd_log[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (acc_write) begin
            wr_dat.push_back(acc_writedata);
            wr_cyc.push_back(cyc);
        end
        if (acc_read) rd_cyc.push_back(cyc);
        if (src_rd) sa_log.push_back(int'(src_addr));
        if (dst_we) begin
            da_log.push_back(int'(dst_addr));
            dd_log.push_back(dst_wdata);
        end
        if (complete) begin
            comp_cnt <= comp_cnt + 1;
            comp_err <= error;
            comp_cyc <= cyc;
        end
        if ((acc_read && acc_write) || acc_chipselect !== (acc_read || acc_write) ||
            (acc_write && acc_address !== LOAD_REG) || (acc_read && acc_address !== READ_REG))
            bad_cnt <= bad_cnt + 1;
    end

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, complete, error, src_rd, src_addr, dst_we, dst_addr, dst_wdata,
                acc_chipselect, acc_address, acc_write, acc_read, acc_writedata};
    endfunction

    task automatic load_src(input bit ramp);
        for (int i = 0; i < 32; i++) src_mem[i] = ramp ? 16'(i * 3) : 16'($urandom);
    endtask

    task automatic prep(input bit nd, input bit pd);
        never_done = nd;
        pre_done = pd;
        done_dly = $urandom_range(0, 8);
        rel_dly = $urandom_range(0, 8);
        model_clr = 1;
        tick();
        model_clr = 0;
    endtask

    task automatic wait_comp(input int base, input string tag);
        int n = 0;
        while (comp_cnt == base && n < 300) begin
            tick();
            n++;
        end
        check({tag, " complete_seen"}, 64'(comp_cnt != base), 1);
    endtask

    task automatic run_txn(input string tag, input bit mid_start);
        int wb = wr_dat.size(), rb = rd_cyc.size(), sb = sa_log.size(), db = da_log.size(), cb = comp_cnt;
        start = 1;
        tick();
        start = 0;
        if (mid_start) begin
            int n = 0;
            while (rd_cyc.size() == rb && n < 200) begin
                tick();
                n++;
            end
            repeat (3) tick();
            start = 1;
            tick();
            start = 0;
        end
        wait_comp(cb, tag);
        repeat (4) tick();
        check({tag, " complete_count"}, 64'(comp_cnt - cb), 1);
        check({tag, " error"}, 64'(comp_err), 0);
        check({tag, " busy_after"}, 64'(busy), 0);
        check({tag, " write_count"}, 64'(wr_dat.size() - wb), 26);
        check({tag, " read_count"}, 64'(rd_cyc.size() - rb), 26);
        check({tag, " src_rd_count"}, 64'(sa_log.size() - sb), 25);
        check({tag, " dst_we_count"}, 64'(da_log.size() - db), 25);
        if (wr_dat.size() - wb == 26) begin
            for (int i = 0; i < 25; i++) check({tag, " load_word"}, 64'(wr_dat[wb + i]), 64'(src_mem[i]));
            check({tag, " commit_data"}, 64'(wr_dat[wb + 25]), 0);
        end
        if (sa_log.size() - sb == 25)
            for (int i = 0; i < 25; i++) check({tag, " src_addr"}, 64'(sa_log[sb + i]), 64'(i));
        if (da_log.size() - db == 25)
            for (int i = 0; i < 25; i++) begin
                check({tag, " dst_addr"}, 64'(da_log[db + i]), 64'(i));
                check({tag, " dst_data"}, 64'(dd_log[db + i]), 64'(16'(src_mem[i] + 16'd5)));
            end
        check({tag, " bus_rules"}, 64'(bad_cnt), 0);
    endtask

    initial begin
        int wb, rb, db, cb, sb, n;
        for (int i = 0; i < 32; i++) src_mem[i] = 0;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 0);
        reset = 0;
        tick();
        check("idle_outputs", all_outs(), 0);

        load_src(1);
        prep(0, 0);
        run_txn("normal_ramp", 0);

        for (int k = 0; k < 3; k++) begin
            load_src(0);
            prep(0, 0);
            run_txn("normal_rand", 0);
        end

        load_src(0);
        prep(1, 0);
        wb = wr_dat.size(); rb = rd_cyc.size(); db = da_log.size(); cb = comp_cnt;
        start = 1;
        tick();
        start = 0;
        wait_comp(cb, "timeout");
        repeat (3) tick();
        check("timeout error", 64'(comp_err), 1);
        check("timeout complete_count", 64'(comp_cnt - cb), 1);
        check("timeout read_count", 64'(rd_cyc.size() - rb), 0);
        check("timeout dst_we_count", 64'(da_log.size() - db), 0);
        check("timeout busy_after", 64'(busy), 0);
        if (wr_dat.size() - wb == 26) check("timeout latency", 64'(comp_cyc - (wr_cyc[wb + 25] + 1)), 16);
        else check("timeout write_count", 64'(wr_dat.size() - wb), 26);

        load_src(0);
        prep(0, 0);
        cb = comp_cnt;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (!(src_rd && src_addr == 5'd10) && n < 50) begin
            tick();
            n++;
        end
        check("abort reached_word10", 64'(src_rd && src_addr == 5'd10), 1);
        abort = 1;
        tick();
        abort = 0;
        check("abort strobes", 64'({src_rd, acc_write, acc_read, dst_we, acc_chipselect, busy, complete}), 0);
        repeat (20) tick();
        check("abort no_complete", 64'(comp_cnt - cb), 0);
        prep(0, 0);
        run_txn("after_abort", 0);

        load_src(0);
        prep(0, 0);
        run_txn("start_in_drain", 1);

        sb = sa_log.size();
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        check("start_abort busy", 64'(busy), 0);
        repeat (3) tick();
        check("start_abort src_rd_count", 64'(sa_log.size() - sb), 0);
        check("start_abort idle", 64'(busy), 0);

        load_src(0);
        prep(1, 0);
        wb = wr_dat.size();
        cb = comp_cnt;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (wr_dat.size() - wb < 26 && n < 60) begin
            tick();
            n++;
        end
        check("reset_mid commit_seen", 64'(wr_dat.size() - wb), 26);
        tick();
        reset = 1;
        tick();
        check("reset_mid outputs", all_outs(), 0);
        reset = 0;
        repeat (20) tick();
        check("reset_mid idle", all_outs(), 0);
        check("reset_mid no_complete", 64'(comp_cnt - cb), 0);

        load_src(0);
        prep(0, 1);
        wb = wr_dat.size();
        rb = rd_cyc.size();
        run_txn("pre_done", 0);
        if (wr_dat.size() - wb == 26 && rd_cyc.size() > rb)
            check("pre_done drain_latency", 64'(rd_cyc[rb] - wr_cyc[wb + 25]), 2);
        else check("pre_done traffic", 64'(rd_cyc.size() > rb), 1);

        check("bus_rules final", 64'(bad_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
